// File: rtl/riscv_alu_issue.sv
// Single-issue ALU front end: decodes one RV64 integer instruction, drives an external ALU
// for one cycle and holds the captured result until the consumer accepts it.
module riscv_alu_issue (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic [63:0] rs1_val,
  input  logic [63:0] rs2_val,
  input  logic [63:0] imm,
  output logic [3:0]  alu_ctl,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  input  logic [63:0] alu_out,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_taken,
  output logic        rsp_illegal,
  output logic [15:0] op_count
);

  // state | meaning
  // IDLE  | waiting for a request (ready once out of reset)
  // EXEC  | ALU operands applied, result captured at end of cycle
  // RESP  | response held until rsp_ready
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  typedef enum logic [1:0] {BR_NONE, BR_EQ, BR_NE} br_t;

  localparam logic [3:0] CTL_AND = 4'd0;
  localparam logic [3:0] CTL_OR  = 4'd1;
  localparam logic [3:0] CTL_ADD = 4'd2;
  localparam logic [3:0] CTL_SUB = 4'd6;
  localparam logic [3:0] CTL_SLT = 4'd7;

  state_t      state, state_nxt;
  br_t         br_q, dec_br;
  logic        started;
  logic        accept;
  logic        dec_legal;
  logic        dec_use_imm;
  logic [3:0]  dec_ctl;
  logic [15:0] cnt_q;

  assign accept   = req_valid && req_ready;
  assign op_count = cnt_q;

  always_comb begin
    dec_legal   = 1'b0;
    dec_use_imm = 1'b0;
    dec_ctl     = CTL_ADD;
    dec_br      = BR_NONE;
    case (opcode)
      7'b0110011: begin
        dec_legal = 1'b1;
        case (funct3)
          3'b000:  dec_ctl = funct7_5 ? CTL_SUB : CTL_ADD;
          3'b111:  dec_ctl = CTL_AND;
          3'b110:  dec_ctl = CTL_OR;
          3'b010:  dec_ctl = CTL_SLT;
          default: dec_legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        dec_legal   = 1'b1;
        dec_use_imm = 1'b1;
        case (funct3)
          3'b000:  dec_ctl = CTL_ADD;
          3'b111:  dec_ctl = CTL_AND;
          3'b110:  dec_ctl = CTL_OR;
          3'b010:  dec_ctl = CTL_SLT;
          default: dec_legal = 1'b0;
        endcase
      end
      7'b0000011, 7'b0100011: begin
        dec_legal   = 1'b1;
        dec_use_imm = 1'b1;
      end
      7'b1100011: begin
        dec_ctl = CTL_SUB;
        if (funct3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_br    = BR_EQ;
        end else if (funct3 == 3'b001) begin
          dec_legal = 1'b1;
          dec_br    = BR_NE;
        end
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = dec_legal ? EXEC : RESP;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // started keeps req_ready low until the first edge after reset release
  always_comb begin
    req_ready = started && (state == IDLE);
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      started     <= 1'b0;
      br_q        <= BR_NONE;
      alu_ctl     <= 4'd0;
      alu_a       <= 64'd0;
      alu_b       <= 64'd0;
      rsp_result  <= 64'd0;
      rsp_zero    <= 1'b0;
      rsp_taken   <= 1'b0;
      rsp_illegal <= 1'b0;
      cnt_q       <= 16'd0;
    end else begin
      started <= 1'b1;
      if (accept) begin
        if (dec_legal) begin
          alu_ctl <= dec_ctl;
          alu_a   <= rs1_val;
          alu_b   <= dec_use_imm ? imm : rs2_val;
          br_q    <= dec_br;
        end else begin
          rsp_result  <= 64'd0;
          rsp_zero    <= 1'b0;
          rsp_taken   <= 1'b0;
          rsp_illegal <= 1'b1;
        end
      end
      if (state == EXEC) begin
        rsp_result  <= alu_out;
        rsp_zero    <= alu_zero;
        rsp_taken   <= (br_q == BR_EQ) ? alu_zero : ((br_q == BR_NE) ? !alu_zero : 1'b0);
        rsp_illegal <= 1'b0;
      end
      if (state == RESP && rsp_ready) cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_riscv_alu_issue.sv
// Randomised bench for riscv_alu_issue: a behavioural ALU drives alu_out, and an
// instruction-level reference model predicts every response and counter value.
module tb_riscv_alu_issue;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7_5 = 1'b0;
  logic [63:0] rs1_val = '0, rs2_val = '0, imm = '0;
  logic [3:0]  alu_ctl;
  logic [63:0] alu_a, alu_b, alu_out;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_result;
  logic        rsp_zero, rsp_taken, rsp_illegal;
  logic [15:0] op_count;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] m_count = 16'd0;
  logic [3:0]  m_ctl = 4'd0;
  logic [63:0] m_a = 64'd0, m_b = 64'd0;

  riscv_alu_issue dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_taken(rsp_taken), .rsp_illegal(rsp_illegal), .op_count(op_count)
  );

  always #5 clock = ~clock;

  // external ALU
  always_comb begin
    case (alu_ctl)
      4'd0:    alu_out = alu_a & alu_b;
      4'd1:    alu_out = alu_a | alu_b;
      4'd2:    alu_out = alu_a + alu_b;
      4'd6:    alu_out = alu_a - alu_b;
      4'd7:    alu_out = ($signed(alu_a) < $signed(alu_b)) ? 64'd1 : 64'd0;
      4'd12:   alu_out = ~(alu_a | alu_b);
      default: alu_out = 64'd0;
    endcase
    alu_zero = (alu_out == 64'd0);
  end

  // Instruction semantics: what the response must contain for a given instruction.
  function automatic void ref_model(
    input  logic [6:0] op, input logic [2:0] f3, input logic f7,
    input  logic [63:0] r1, input logic [63:0] r2, input logic [63:0] im,
    output logic legal, output logic [3:0] ctl, output logic [63:0] a,
    output logic [63:0] b, output logic [63:0] res, output logic taken);
    logic [63:0] src2;
    legal = 1'b0; ctl = 4'd0; a = r1; b = r2; res = 64'd0; taken = 1'b0;
    if (op == 7'b0110011 || op == 7'b0010011) begin
      src2 = (op == 7'b0010011) ? im : r2;
      b = src2;
      legal = 1'b1;
      if (f3 == 3'b000 && op == 7'b0110011 && f7) begin ctl = 4'd6; res = r1 - src2; end
      else if (f3 == 3'b000) begin ctl = 4'd2; res = r1 + src2; end
      else if (f3 == 3'b111) begin ctl = 4'd0; res = r1 & src2; end
      else if (f3 == 3'b110) begin ctl = 4'd1; res = r1 | src2; end
      else if (f3 == 3'b010) begin ctl = 4'd7; res = ($signed(r1) < $signed(src2)) ? 64'd1 : 64'd0; end
      else legal = 1'b0;
    end else if (op == 7'b0000011 || op == 7'b0100011) begin
      legal = 1'b1; ctl = 4'd2; b = im; res = r1 + im;
    end else if (op == 7'b1100011 && (f3 == 3'b000 || f3 == 3'b001)) begin
      legal = 1'b1; ctl = 4'd6; res = r1 - r2;
      taken = (f3 == 3'b000) ? (r1 == r2) : (r1 != r2);
    end
    if (!legal) begin res = 64'd0; taken = 1'b0; end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete transaction with `hold` cycles of response backpressure.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [63:0] r1, input logic [63:0] r2, input logic [63:0] im,
                       input int hold);
    logic legal, taken;
    logic [3:0] ctl;
    logic [63:0] a, b, res;
    logic [66:0] snap;
    int waited = 0;
    ref_model(op, f3, f7, r1, r2, im, legal, ctl, a, b, res, taken);
    while (!req_ready && waited < 10) begin tick(); waited++; end
    vectors++;
    if (!req_ready) begin
      miscompares++;
      $display("FAIL ready_timeout: req_ready=%0b required 1 within 10 cycles", req_ready);
      return;
    end
    opcode = op; funct3 = f3; funct7_5 = f7; rs1_val = r1; rs2_val = r2; imm = im;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    tick();
    req_valid = (hold > 0);
    if (legal) begin
      m_ctl = ctl; m_a = a; m_b = b;
      vectors++;
      if ({rsp_valid, req_ready, alu_ctl, alu_a, alu_b} !== {2'b00, ctl, a, b}) begin
        miscompares++;
        $display("FAIL exec_operands: valid=%0b ready=%0b ctl=%0d a=%h b=%h required 0 0 %0d %h %h",
                 rsp_valid, req_ready, alu_ctl, alu_a, alu_b, ctl, a, b);
      end
      tick();
    end
    vectors++;
    if ({rsp_valid, rsp_result, rsp_zero, rsp_taken, rsp_illegal, alu_ctl, alu_a, alu_b} !==
        {1'b1, res, legal && (res == 64'd0), taken, !legal, m_ctl, m_a, m_b}) begin
      miscompares++;
      $display("FAIL response(op=%b f3=%b): valid=%0b res=%h z=%0b t=%0b ill=%0b ctl=%0d required 1 %h %0b %0b %0b %0d",
               op, f3, rsp_valid, rsp_result, rsp_zero, rsp_taken, rsp_illegal, alu_ctl,
               res, legal && (res == 64'd0), taken, !legal, m_ctl);
    end
    snap = {rsp_result, rsp_zero, rsp_taken, rsp_illegal};
    for (int i = 0; i < hold; i++) begin
      tick();
      vectors++;
      if ({rsp_valid, req_ready, rsp_result, rsp_zero, rsp_taken, rsp_illegal, op_count} !==
          {2'b10, snap, m_count}) begin
        miscompares++;
        $display("FAIL backpressure_hold[%0d]: valid=%0b ready=%0b rsp=%h count=%0d required 1 0 %h %0d",
                 i, rsp_valid, req_ready, {rsp_result, rsp_zero, rsp_taken, rsp_illegal},
                 op_count, snap, m_count);
      end
    end
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    m_count = m_count + 16'd1;
    vectors++;
    if ({rsp_valid, req_ready, op_count} !== {2'b01, m_count}) begin
      miscompares++;
      $display("FAIL handshake: valid=%0b ready=%0b count=%0d required 0 1 %0d",
               rsp_valid, req_ready, op_count, m_count);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    vectors++;
    if ({req_ready, rsp_valid, alu_ctl, alu_a, alu_b, rsp_result, rsp_zero, rsp_taken, rsp_illegal, op_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: ready=%0b valid=%0b ctl=%0d a=%h b=%h res=%h count=%0d required all zero",
               req_ready, rsp_valid, alu_ctl, alu_a, alu_b, rsp_result, op_count);
    end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_before_edge: req_ready=%0b required 0", req_ready);
    end
    tick();
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: req_ready=%0b required 1", req_ready);
    end
  endtask

  task automatic test_add();
    issue(7'b0110011, 3'b000, 1'b0, 64'd5, 64'd7, 64'd0, 0);
  endtask

  task automatic test_branch();
    issue(7'b1100011, 3'b000, 1'b0, 64'h1234, 64'h1234, 64'd0, 0);
    issue(7'b1100011, 3'b001, 1'b0, 64'h1234, 64'h1234, 64'd0, 0);
    issue(7'b1100011, 3'b001, 1'b0, 64'h1234, 64'h1235, 64'd0, 1);
    issue(7'b1100011, 3'b000, 1'b0, 64'h1, 64'h2, 64'd0, 0);
  endtask

  task automatic test_illegal();
    issue(7'b1111111, 3'b000, 1'b0, 64'd9, 64'd9, 64'd9, 0);
    issue(7'b1100011, 3'b100, 1'b0, 64'd3, 64'd3, 64'd0, 2);
    issue(7'b0110011, 3'b001, 1'b0, 64'd3, 64'd3, 64'd0, 0);
  endtask

  task automatic test_backpressure();
    issue(7'b0010011, 3'b110, 1'b0, 64'hF0, 64'd0, 64'h0F, 5);
    issue(7'b0110011, 3'b010, 1'b0, -64'sd4, 64'd3, 64'd0, 5);
  endtask

  task automatic test_reset_mid_op();
    issue(7'b0000011, 3'b011, 1'b0, 64'd100, 64'd0, 64'd8, 0);
    opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b1;
    rs1_val = 64'd50; rs2_val = 64'd8; req_valid = 1'b1; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    m_count = 16'd0; m_ctl = 4'd0; m_a = 64'd0; m_b = 64'd0;
    vectors++;
    if ({req_ready, rsp_valid, alu_ctl, alu_a, alu_b, rsp_result, rsp_zero, rsp_taken, rsp_illegal, op_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_op: ready=%0b valid=%0b ctl=%0d a=%h b=%h res=%h count=%0d required all zero",
               req_ready, rsp_valid, alu_ctl, alu_a, alu_b, rsp_result, op_count);
    end
    tick();
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if ({rsp_valid, req_ready, op_count} !== {2'b01, 16'd0}) begin
        miscompares++;
        $display("FAIL post_reset_idle[%0d]: valid=%0b ready=%0b count=%0d required 0 1 0",
                 i, rsp_valid, req_ready, op_count);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [6] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0};
    logic [6:0] op;
    logic [63:0] r1, r2;
    for (int n = 0; n < 200; n++) begin
      op = ops[$urandom_range(0, 5)];
      if (op == 7'b0) op = 7'($urandom);
      r1 = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
      r2 = ($urandom_range(0, 2) == 0) ? r1 : {$urandom, $urandom};
      issue(op, 3'($urandom), 1'($urandom), r1, r2, {$urandom, $urandom}, $urandom_range(0, 3));
    end
  endtask

  task automatic test_wrap();
    @(negedge clock);
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    m_count = 16'hFFFF;
    issue(7'b0010011, 3'b000, 1'b0, 64'd1, 64'd0, 64'd1, 0);
    vectors++;
    if (op_count !== 16'h0000) begin
      miscompares++;
      $display("FAIL count_wrap: op_count=%h required 0000", op_count);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_illegal();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
